// File: rtl/gps_nmea_tx_pkg.sv
// Shared types and constants for the GPRMC sentence transmitter.
// Macro GPS_NMEA_TX_CKSUM_EN adds the "*hh" checksum trailer states.
package gps_nmea_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        HDR   = 4'd1,
        TIME  = 4'd2,
        SEP   = 4'd3,
        STAT  = 4'd4,
`ifdef GPS_NMEA_TX_CKSUM_EN
        STAR  = 4'd5,
        CK_HI = 4'd6,
        CK_LO = 4'd7,
`endif
        CR    = 4'd8,
        LF    = 4'd9
    } state_t;

    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;
    localparam logic [7:0] ASC_STAR   = 8'h2A;
    localparam logic [7:0] ASC_A      = 8'h41;
    localparam logic [7:0] ASC_V      = 8'h56;
    localparam logic [7:0] ASC_CR     = 8'h0D;
    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_0      = 8'h30;

    localparam logic [7:0] HDR_BYTES [0:5] = '{8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C};

    localparam int SENTENCE_LEN_CKSUM   = 20;
    localparam int SENTENCE_LEN_NOCKSUM = 17;
`ifdef GPS_NMEA_TX_CKSUM_EN
    localparam int SENTENCE_LEN = SENTENCE_LEN_CKSUM;
`else
    localparam int SENTENCE_LEN = SENTENCE_LEN_NOCKSUM;
`endif

    // Out-of-range BCD nibbles are emitted as '0'
    function automatic logic [7:0] bcd_ascii(input logic [3:0] n);
        if (n > 4'd9) begin
            return ASC_0;
        end else begin
            return ASC_0 + {4'h0, n};
        end
    endfunction

endpackage

// File: rtl/gps_nmea_tx_hex.sv
// Combinational nibble to uppercase ASCII hex digit.
module gps_hex_ascii (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);
    assign ascii = (nib > 4'd9) ? (8'h37 + {4'h0, nib}) : (8'h30 + {4'h0, nib});
endmodule

// File: rtl/gps_nmea_tx.sv
// Streams one "$GPRMC,hhmmss,S[*hh]\r\n" sentence per accepted start over valid/ready.
// Macro GPS_NMEA_TX_CKSUM_EN enables the checksum trailer (20 bytes vs 17).
module gps_nmea_tx
    import gps_nmea_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] time_bcd,
    input  logic        fix_valid,
    input  logic        gps_ready_in,
    output logic        gps_valid_out,
    output logic [7:0]  gps_data_out,
    output logic        busy,
    output logic        done
);
    state_t      state_r;
    state_t      nxt_state_s;
    logic [2:0]  idx_r;
    logic [2:0]  nxt_idx_s;
    logic [23:0] time_r;
    logic        stat_r;
    logic [3:0]  nib_s;
    logic [7:0]  byte_s;
    logic        xfer_s;
    logic        accept_s;
`ifdef GPS_NMEA_TX_CKSUM_EN
    logic [7:0]  cksum_r;
    logic        cks_en_s;
    logic [7:0]  hex_hi_s;
    logic [7:0]  hex_lo_s;

    gps_hex_ascii u_hex_hi (.nib(cksum_r[7:4]), .ascii(hex_hi_s));
    gps_hex_ascii u_hex_lo (.nib(cksum_r[3:0]), .ascii(hex_lo_s));
`endif

    assign xfer_s   = gps_valid_out & gps_ready_in;
    // The done cycle is already IDLE but must not accept a new start
    assign accept_s = (state_r == IDLE) & start & ~done;

    // Next state/index, and the byte that will be presented in that state
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r;
        nib_s       = 4'h0;
        byte_s      = 8'h00;
`ifdef GPS_NMEA_TX_CKSUM_EN
        cks_en_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                nxt_state_s = HDR;
                nxt_idx_s   = 3'd0;
            end
            HDR: begin
`ifdef GPS_NMEA_TX_CKSUM_EN
                cks_en_s = (idx_r != 3'd0);
`endif
                if (idx_r == 3'd6) begin
                    nxt_state_s = TIME;
                    nxt_idx_s   = 3'd0;
                end else begin
                    nxt_idx_s = idx_r + 3'd1;
                end
            end
            TIME: begin
`ifdef GPS_NMEA_TX_CKSUM_EN
                cks_en_s = 1'b1;
`endif
                if (idx_r == 3'd5) begin
                    nxt_state_s = SEP;
                    nxt_idx_s   = 3'd0;
                end else begin
                    nxt_idx_s = idx_r + 3'd1;
                end
            end
            SEP: begin
`ifdef GPS_NMEA_TX_CKSUM_EN
                cks_en_s = 1'b1;
`endif
                nxt_state_s = STAT;
            end
`ifdef GPS_NMEA_TX_CKSUM_EN
            STAT: begin
                cks_en_s    = 1'b1;
                nxt_state_s = STAR;
            end
            STAR:    nxt_state_s = CK_HI;
            CK_HI:   nxt_state_s = CK_LO;
            CK_LO:   nxt_state_s = CR;
`else
            STAT:    nxt_state_s = CR;
`endif
            CR:      nxt_state_s = LF;
            LF:      nxt_state_s = IDLE;
            default: nxt_state_s = IDLE;
        endcase

        case (nxt_idx_s)
            3'd0:    nib_s = time_r[23:20];
            3'd1:    nib_s = time_r[19:16];
            3'd2:    nib_s = time_r[15:12];
            3'd3:    nib_s = time_r[11:8];
            3'd4:    nib_s = time_r[7:4];
            3'd5:    nib_s = time_r[3:0];
            default: nib_s = 4'h0;
        endcase

        case (nxt_state_s)
            HDR: begin
                if (nxt_idx_s == 3'd0) begin
                    byte_s = ASC_DOLLAR;
                end else begin
                    byte_s = HDR_BYTES[nxt_idx_s - 3'd1];
                end
            end
            TIME:    byte_s = bcd_ascii(nib_s);
            SEP:     byte_s = ASC_COMMA;
            STAT:    byte_s = stat_r ? ASC_A : ASC_V;
`ifdef GPS_NMEA_TX_CKSUM_EN
            STAR:    byte_s = ASC_STAR;
            CK_HI:   byte_s = hex_hi_s;
            CK_LO:   byte_s = hex_lo_s;
`endif
            CR:      byte_s = ASC_CR;
            LF:      byte_s = ASC_LF;
            default: byte_s = 8'h00;
        endcase
    end

    // Sentence sequencer with registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            idx_r         <= 3'd0;
            time_r        <= 24'h000000;
            stat_r        <= 1'b0;
            gps_valid_out <= 1'b0;
            gps_data_out  <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef GPS_NMEA_TX_CKSUM_EN
            cksum_r       <= 8'h00;
`endif
        end else if (accept_s) begin
            state_r       <= nxt_state_s;
            idx_r         <= nxt_idx_s;
            time_r        <= time_bcd;
            stat_r        <= fix_valid;
            gps_valid_out <= 1'b1;
            gps_data_out  <= byte_s;
            busy          <= 1'b1;
            done          <= 1'b0;
`ifdef GPS_NMEA_TX_CKSUM_EN
            cksum_r       <= 8'h00;
`endif
        end else if (xfer_s) begin
            state_r <= nxt_state_s;
            idx_r   <= nxt_idx_s;
`ifdef GPS_NMEA_TX_CKSUM_EN
            if (cks_en_s) begin
                cksum_r <= cksum_r ^ gps_data_out;
            end
`endif
            if (state_r == LF) begin
                gps_valid_out <= 1'b0;
                gps_data_out  <= 8'h00;
                busy          <= 1'b0;
                done          <= 1'b1;
            end else begin
                gps_data_out  <= byte_s;
                done          <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gps_nmea_tx.sv
// Directed self-checking bench for gps_nmea_tx; expectations follow GPS_NMEA_TX_CKSUM_EN.
module tb_gps_nmea_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] time_bcd = 24'h000000;
    logic        fix_valid = 1'b0;
    logic        gps_ready_in = 1'b0;
    logic        gps_valid_out;
    logic [7:0]  gps_data_out;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    logic [7:0] got_q [0:63];
    int got_n, done_cyc, stall_bad, busy_bad;

    string exp_a, exp_v, exp_n;
    int    len;

    gps_nmea_tx dut (
        .clk(clk), .rst_n(rst_n), .start(start), .time_bcd(time_bcd),
        .fix_valid(fix_valid), .gps_ready_in(gps_ready_in),
        .gps_valid_out(gps_valid_out), .gps_data_out(gps_data_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Called just after a negedge: issues start, then collects transferred bytes until done.
    // pat 0 = ready always 1; pat 1 = ready 1,0,0,1,0,0...; poke disturbs start/inputs mid-sentence.
    task automatic run_sentence(input logic [23:0] t, input logic f, input int pat, input bit poke);
        logic [7:0] prev_d;
        logic       prev_stall;
        got_n = 0; done_cyc = -1; stall_bad = 0; busy_bad = 0;
        prev_d = 8'h00; prev_stall = 1'b0;
        time_bcd = t; fix_valid = f; start = 1'b1; gps_ready_in = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke) begin
                time_bcd  = 24'h987654;
                fix_valid = ~f;
                if (c == 5 || c == 12) start = 1'b1;
            end
            if (done) begin
                done_cyc = c;
                if (poke) start = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (prev_stall && (gps_data_out !== prev_d || gps_valid_out !== 1'b1)) stall_bad++;
            gps_ready_in = (pat == 0) ? 1'b1 : ((c % 3) == 1);
            prev_stall = gps_valid_out && !gps_ready_in;
            prev_d = gps_data_out;
            if (gps_valid_out && gps_ready_in && got_n < 64) begin
                got_q[got_n] = gps_data_out;
                got_n++;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({gps_valid_out, gps_data_out, busy, done} !== 11'h000) begin
            $display("FAIL reset_outputs got v=%b d=%h b=%b dn=%b want all 0",
                     gps_valid_out, gps_data_out, busy, done);
            bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_sentence(24'h123456, 1'b1, 0, 1'b0);
        total++;
        if (got_n !== len) begin
            $display("FAIL basic_len got %0d want %0d", got_n, len); bad++;
        end
        for (int i = 0; i < len; i++) begin
            total++;
            if (got_q[i] !== exp_a[i]) begin
                $display("FAIL basic_byte%0d got %h want %h", i, got_q[i], exp_a[i]); bad++;
            end
        end
        total++;
        if (done_cyc !== len + 1) begin
            $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, len + 1); bad++;
        end
        total++;
        if (busy_bad !== 0) begin
            $display("FAIL basic_busy got %0d low cycles want 0", busy_bad); bad++;
        end
        total++;
        if (gps_valid_out !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_done_state got v=%b b=%b want 0 0", gps_valid_out, busy); bad++;
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            $display("FAIL basic_done_pulse got %b want 0", done); bad++;
        end
    endtask

    task automatic test_void();
        run_sentence(24'h123456, 1'b0, 0, 1'b0);
        total++;
        if (got_n !== len) begin
            $display("FAIL void_len got %0d want %0d", got_n, len); bad++;
        end
        for (int i = 0; i < len; i++) begin
            total++;
            if (got_q[i] !== exp_v[i]) begin
                $display("FAIL void_byte%0d got %h want %h", i, got_q[i], exp_v[i]); bad++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        run_sentence(24'h123456, 1'b1, 1, 1'b0);
        total++;
        if (stall_bad !== 0) begin
            $display("FAIL bp_stall_stable got %0d violations want 0", stall_bad); bad++;
        end
        total++;
        if (got_n !== len) begin
            $display("FAIL bp_len got %0d want %0d", got_n, len); bad++;
        end
        for (int i = 0; i < len; i++) begin
            total++;
            if (got_q[i] !== exp_a[i]) begin
                $display("FAIL bp_byte%0d got %h want %h", i, got_q[i], exp_a[i]); bad++;
            end
        end
        total++;
        if (done_cyc !== 3 * len - 1) begin
            $display("FAIL bp_done_cycle got %0d want %0d", done_cyc, 3 * len - 1); bad++;
        end
        gps_ready_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        run_sentence(24'h123456, 1'b1, 0, 1'b1);
        for (int i = 0; i < len; i++) begin
            total++;
            if (got_q[i] !== exp_a[i]) begin
                $display("FAIL ign_byte%0d got %h want %h", i, got_q[i], exp_a[i]); bad++;
            end
        end
        total++;
        if (done_cyc !== len + 1) begin
            $display("FAIL ign_done_cycle got %0d want %0d", done_cyc, len + 1); bad++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (gps_valid_out !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL ign_no_second got v=%b b=%b want 0 0 at +%0d", gps_valid_out, busy, k); bad++;
            end
        end
        time_bcd = 24'h000000;
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        time_bcd = 24'h123456; fix_valid = 1'b1; gps_ready_in = 1'b1; start = 1'b1;
        for (int c = 1; c <= 100 && n < 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (gps_valid_out && gps_ready_in) n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({gps_valid_out, gps_data_out, busy, done} !== 11'h000) begin
            $display("FAIL midrst_outputs got v=%b d=%h b=%b dn=%b want all 0",
                     gps_valid_out, gps_data_out, busy, done); bad++;
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            $display("FAIL midrst_done got %b want 0", done); bad++;
        end
        rst_n = 1'b1;
        run_sentence(24'h123456, 1'b1, 0, 1'b0);
        total++;
        if (got_n !== len || done_cyc !== len + 1) begin
            $display("FAIL midrst_after got n=%0d done=%0d want %0d %0d", got_n, done_cyc, len, len + 1); bad++;
        end
        for (int i = 0; i < len; i++) begin
            total++;
            if (got_q[i] !== exp_a[i]) begin
                $display("FAIL midrst_byte%0d got %h want %h", i, got_q[i], exp_a[i]); bad++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_bad_nibble();
        run_sentence(24'h0A5959, 1'b1, 0, 1'b0);
        total++;
        if (got_n !== len) begin
            $display("FAIL nib_len got %0d want %0d", got_n, len); bad++;
        end
        for (int i = 0; i < len; i++) begin
            total++;
            if (got_q[i] !== exp_n[i]) begin
                $display("FAIL nib_byte%0d got %h want %h", i, got_q[i], exp_n[i]); bad++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
`ifdef GPS_NMEA_TX_CKSUM_EN
        exp_a = "$GPRMC,123456,A*0D\015\012";
        exp_v = "$GPRMC,123456,V*1A\015\012";
        exp_n = "$GPRMC,005959,A*0A\015\012";
        len   = 20;
`else
        exp_a = "$GPRMC,123456,A\015\012";
        exp_v = "$GPRMC,123456,V\015\012";
        exp_n = "$GPRMC,005959,A\015\012";
        len   = 17;
`endif
        @(negedge clk);
        test_reset();
        test_basic();
        test_void();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_bad_nibble();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
